// File: rtl/bank_access_controller.sv
// bank_access_controller: two-port round-robin sequencer for one bank's
// word-line decoder (setup / pulse / hold timing, one-cycle ack).
module bank_access_controller #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    input  logic              req0_valid,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic              req0_write,
    input  logic              req1_write,
    output logic              req0_ack,
    output logic              req1_ack,
    input  logic [CNT_W-1:0]  cfg_setup,
    input  logic [CNT_W-1:0]  cfg_pulse,
    input  logic [CNT_W-1:0]  cfg_hold,
    output logic [ADDR_W-1:0] sel,
    output logic              wl_en,
    output logic              wr_en,
    output logic              busy,
    output logic [1:0]        grant
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        DONE
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [CNT_W-1:0]   lat_pulse, lat_pulse_n;
    logic [CNT_W-1:0]   lat_hold, lat_hold_n;
    logic               lat_wr, lat_wr_n;
    logic               ptr, ptr_n;
    logic               pick1;
    logic [ADDR_W-1:0]  sel_n;
    logic [1:0]         grant_n;

    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_W'(1) : v;
    endfunction

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        lat_pulse_n = lat_pulse;
        lat_hold_n  = lat_hold;
        lat_wr_n    = lat_wr;
        ptr_n       = ptr;
        sel_n       = sel;
        grant_n     = grant;
        pick1       = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    // req1 wins when alone or when it holds the pointer
                    pick1       = req1_valid && (!req0_valid || ptr);
                    ptr_n       = !pick1;
                    grant_n     = pick1 ? 2'b10 : 2'b01;
                    sel_n       = pick1 ? req1_addr : req0_addr;
                    lat_wr_n    = pick1 ? req1_write : req0_write;
                    lat_pulse_n = cfg_pulse;
                    lat_hold_n  = cfg_hold;
                    if (cfg_setup != '0) begin
                        state_n = SETUP;
                        cnt_n   = cfg_setup;
                    end else begin
                        state_n = PULSE;
                        cnt_n   = at_least_one(cfg_pulse);
                    end
                end
            end
            SETUP: begin
                if (cnt == CNT_W'(1)) begin
                    state_n = PULSE;
                    cnt_n   = at_least_one(lat_pulse);
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            PULSE: begin
                if (cnt == CNT_W'(1)) begin
                    state_n = (lat_hold != '0) ? HOLD : DONE;
                    cnt_n   = lat_hold;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt == CNT_W'(1)) state_n = DONE;
                else                  cnt_n   = cnt - CNT_W'(1);
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (state_n == IDLE) grant_n = 2'b00;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_pulse <= '0;
            lat_hold  <= '0;
            lat_wr    <= 1'b0;
            ptr       <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            lat_pulse <= lat_pulse_n;
            lat_hold  <= lat_hold_n;
            lat_wr    <= lat_wr_n;
            ptr       <= ptr_n;
        end
    end

    // outputs decoded from next state so they line up with the state register
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            sel      <= '0;
            grant    <= 2'b00;
            wl_en    <= 1'b0;
            wr_en    <= 1'b0;
            busy     <= 1'b0;
            req0_ack <= 1'b0;
            req1_ack <= 1'b0;
        end else begin
            sel      <= sel_n;
            grant    <= grant_n;
            wl_en    <= (state_n == PULSE);
            wr_en    <= (state_n == PULSE) && lat_wr_n;
            busy     <= (state_n != IDLE);
            req0_ack <= (state_n == DONE) && grant_n[0];
            req1_ack <= (state_n == DONE) && grant_n[1];
        end
    end

endmodule

// File: tb/tb_bank_access_controller.sv
// tb_bank_access_controller: directed vectors for the bank access
// sequencer with hand-computed cycle expectations.
module tb_bank_access_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v0, v1, w0, w1;
    logic [9:0] a0, a1;
    logic       ack0, ack1;
    logic [3:0] cs, cp, ch;
    logic [9:0] sel;
    logic       wl_en, wr_en, busy;
    logic [1:0] grant;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bank_access_controller #(.ADDR_W(10), .CNT_W(4)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n   (rst_n),
        .req0_valid (v0),
        .req1_valid (v1),
        .req0_addr  (a0),
        .req1_addr  (a1),
        .req0_write (w0),
        .req1_write (w1),
        .req0_ack   (ack0),
        .req1_ack   (ack1),
        .cfg_setup  (cs),
        .cfg_pulse  (cp),
        .cfg_hold   (ch),
        .sel        (sel),
        .wl_en      (wl_en),
        .wr_en      (wr_en),
        .busy       (busy),
        .grant      (grant)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ack_k;
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; w0 = 1'b0; w1 = 1'b0;
        a0 = '0; a1 = '0;
        cs = '0; cp = '0; ch = '0;

        // reset held with req0 pending
        v0 = 1'b1; a0 = 10'h155;
        tick(); tick();
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_wl", 32'(wl_en), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_ack0", 32'(ack0), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("first_grant", 32'(grant), 32'h1);
        chk("first_sel", 32'(sel), 32'h155);
        chk("first_wl", 32'(wl_en), 32'h1);
        chk("first_busy", 32'(busy), 32'h1);
        tick();
        chk("first_ack", 32'(ack0), 32'h1);
        v0 = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_grant", 32'(grant), 32'h0);
        chk("idle_sel_hold", 32'(sel), 32'h155);

        // req0 write to top address, cfg 2/3/1
        a0 = 10'h3FF; w0 = 1'b1; cs = 4'd2; cp = 4'd3; ch = 4'd1;
        v0 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("t2_wl_k%0d", k), 32'(wl_en), 32'(k >= 3 && k <= 5));
            chk($sformatf("t2_wr_k%0d", k), 32'(wr_en), 32'(k >= 3 && k <= 5));
            chk($sformatf("t2_ack_k%0d", k), 32'(ack0), 32'(k == 7));
            chk($sformatf("t2_busy_k%0d", k), 32'(busy), 32'(k <= 7));
            chk($sformatf("t2_sel_k%0d", k), 32'(sel), 32'h3FF);
            if (k == 7) v0 = 1'b0;
        end

        // req1 read, pulse 0 -> 1 cycle, cfg changed mid-access
        a1 = 10'h0A5; w1 = 1'b0; cs = 4'd1; cp = 4'd0; ch = 4'd2;
        v1 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) begin
                chk("t3_grant", 32'(grant), 32'h2);
                chk("t3_sel", 32'(sel), 32'h0A5);
                cs = 4'd5; cp = 4'd5; ch = 4'd5;
            end
            chk($sformatf("t3_wl_k%0d", k), 32'(wl_en), 32'(k == 2));
            chk($sformatf("t3_wr_k%0d", k), 32'(wr_en), 32'h0);
            chk($sformatf("t3_ack1_k%0d", k), 32'(ack1), 32'(k == 5));
            chk($sformatf("t3_ack0_k%0d", k), 32'(ack0), 32'h0);
            if (k == 5) v1 = 1'b0;
        end

        // both valid continuously, cfg 0/0/0: alternate grants
        cs = '0; cp = '0; ch = '0;
        a0 = 10'h001; a1 = 10'h002; w0 = 1'b0; w1 = 1'b1;
        v0 = 1'b1; v1 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            int pos, w;
            tick();
            pos = (k - 1) % 3;
            w   = ((k - 1) / 3) % 2;
            chk($sformatf("rr_grant_k%0d", k), 32'(grant),
                (pos == 2) ? 32'h0 : ((w == 1) ? 32'h2 : 32'h1));
            chk($sformatf("rr_ack0_k%0d", k), 32'(ack0), 32'(pos == 1 && w == 0));
            chk($sformatf("rr_ack1_k%0d", k), 32'(ack1), 32'(pos == 1 && w == 1));
            if (pos == 0)
                chk($sformatf("rr_sel_k%0d", k), 32'(sel), (w == 1) ? 32'h2 : 32'h1);
            if (k == 12) begin
                v0 = 1'b0;
                v1 = 1'b0;
            end
        end

        // reset during PULSE of a req1 access
        a1 = 10'h2C3; w1 = 1'b1; cp = 4'd3;
        v1 = 1'b1;
        tick();
        chk("t5_pulse_wl", 32'(wl_en), 32'h1);
        chk("t5_pulse_grant", 32'(grant), 32'h2);
        rst_n = 1'b0;
        tick();
        chk("t5_rst_wl", 32'(wl_en), 32'h0);
        chk("t5_rst_wr", 32'(wr_en), 32'h0);
        chk("t5_rst_busy", 32'(busy), 32'h0);
        chk("t5_rst_grant", 32'(grant), 32'h0);
        chk("t5_rst_sel", 32'(sel), 32'h0);
        chk("t5_rst_ack1a", 32'(ack1), 32'h0);
        tick();
        chk("t5_rst_ack1b", 32'(ack1), 32'h0);
        rst_n = 1'b1;
        ack_k = 0;
        for (int k = 1; k <= 10 && ack_k == 0; k++) begin
            tick();
            if (k == 1) chk("t5_regrant", 32'(grant), 32'h2);
            if (k <= 4) chk($sformatf("t5_wl_k%0d", k), 32'(wl_en), 32'(k <= 3));
            if (ack1) ack_k = k;
        end
        chk("t5_ack_cycle", 32'(ack_k), 32'd4);
        v1 = 1'b0;
        tick();
        chk("t5_end_busy", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
